// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and FSM state type for the data-hazard unit
package hazard_pkg;

  localparam int DEFAULT_ADDR_W = 5;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hazard_state_e;

endpackage

// File: rtl/fwd_stall_hazard_unit_if.sv
// rtl/fwd_stall_hazard_unit_if.sv - ID/EX/MEM hazard bus between pipeline and hazard unit
interface fwd_stall_hazard_unit_if
  import hazard_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int NUM_SRC = 2
);

  logic                        id_valid;
  logic [NUM_SRC*ADDR_W-1:0]   rs_addr_id;
  logic [NUM_SRC-1:0]          rs_used_id;
  logic [ADDR_W-1:0]           ex_rd_addr;
  logic                        ex_reg_write;
  logic                        ex_mem_read;
  logic [ADDR_W-1:0]           mem_rd_addr;
  logic                        mem_reg_write;
  logic                        pipe_hold;
  logic                        flush;
  logic [NUM_SRC*2-1:0]        fwd_sel;
  logic                        stall_pc;
  logic                        stall_id;
  logic                        bubble_ex;

  modport master (
    output id_valid, rs_addr_id, rs_used_id, ex_rd_addr, ex_reg_write, ex_mem_read,
           mem_rd_addr, mem_reg_write, pipe_hold, flush,
    input  fwd_sel, stall_pc, stall_id, bubble_ex
  );

  modport slave (
    input  id_valid, rs_addr_id, rs_used_id, ex_rd_addr, ex_reg_write, ex_mem_read,
           mem_rd_addr, mem_reg_write, pipe_hold, flush,
    output fwd_sel, stall_pc, stall_id, bubble_ex
  );

endinterface

// File: rtl/hazard_addr_cmp.sv
// rtl/hazard_addr_cmp.sv - one source-vs-destination register match, x0 never matches
module hazard_addr_cmp
  import hazard_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic              reg_write,
  input  logic              used,
  output logic              match
);

  assign match = used & reg_write & (rd == rs) & (rd != '0);

endmodule

// File: rtl/fwd_stall_hazard_unit.sv
// rtl/fwd_stall_hazard_unit.sv - forwarding select + load-use stall FSM for the 5-stage pipeline
// Optional perf counters stall_count/fwd_count built when HAZARD_PERF_EN is defined.
module fwd_stall_hazard_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int NUM_SRC      = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  fwd_stall_hazard_unit_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      fwd_count
`endif
);

  localparam int CW = 4;

  if (LOAD_LATENCY < 1 || LOAD_LATENCY > 15 || CNT_W < 1) begin : g_bad_param
    $error("fwd_stall_hazard_unit: LOAD_LATENCY must be 1..15 and CNT_W >= 1");
  end

  logic [NUM_SRC-1:0]   ex_match;
  logic [NUM_SRC-1:0]   mem_match;
  logic                 load_use_hit;
  logic                 stall_act;

  hazard_state_e        state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_SRC*2-1:0] fwd_sel_q, fwd_sel_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_addr_cmp #(.ADDR_W(ADDR_W)) u_ex_cmp (
      .rd        (hz.ex_rd_addr),
      .rs        (hz.rs_addr_id[i*ADDR_W +: ADDR_W]),
      .reg_write (hz.ex_reg_write),
      .used      (hz.rs_used_id[i]),
      .match     (ex_match[i])
    );
    hazard_addr_cmp #(.ADDR_W(ADDR_W)) u_mem_cmp (
      .rd        (hz.mem_rd_addr),
      .rs        (hz.rs_addr_id[i*ADDR_W +: ADDR_W]),
      .reg_write (hz.mem_reg_write),
      .used      (hz.rs_used_id[i]),
      .match     (mem_match[i])
    );
  end

  // Stall is combinational while IDLE so the detection cycle itself is held.
  always_comb begin
    load_use_hit = hz.id_valid & hz.ex_mem_read & (|ex_match);
    stall_act    = reset & ~hz.flush &
                   (((state_q == IDLE) & load_use_hit) | (state_q == STALL));
  end

  // A load still in EX has no data yet, so that source gets no forward at all.
  always_comb begin
    fwd_sel_d = fwd_sel_q;
    if (hz.flush) begin
      fwd_sel_d = '0;
    end else if (!hz.pipe_hold) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (ex_match[i]) begin
          fwd_sel_d[2*i +: 2] = hz.ex_mem_read ? FWD_NONE : FWD_MEM;
        end else if (mem_match[i]) begin
          fwd_sel_d[2*i +: 2] = FWD_WB;
        end else begin
          fwd_sel_d[2*i +: 2] = FWD_NONE;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hz.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (!hz.pipe_hold) begin
      case (state_q)
        IDLE: begin
          if (load_use_hit && LOAD_LATENCY > 1) begin
            state_d = STALL;
            cnt_d   = CW'(LOAD_LATENCY - 1);
          end
        end
        STALL: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      fwd_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

  assign hz.fwd_sel   = fwd_sel_q;
  assign hz.stall_pc  = stall_act;
  assign hz.stall_id  = stall_act;
  assign hz.bubble_ex = stall_act;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] fwd_count_q, fwd_count_d;
  logic             fwd_new;

  always_comb begin
    fwd_new       = ~hz.flush & ~hz.pipe_hold & (|fwd_sel_d);
    stall_count_d = stall_count_q;
    fwd_count_d   = fwd_count_q;
    if (stall_act && !hz.pipe_hold && stall_count_q != '1) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    if (fwd_new && fwd_count_q != '1) begin
      fwd_count_d = fwd_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
      fwd_count_q   <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      fwd_count_q   <= fwd_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign fwd_count   = fwd_count_q;
`endif

endmodule

// File: tb/tb_fwd_stall_hazard_unit.sv
// tb/tb_fwd_stall_hazard_unit.sv - bench for fwd_stall_hazard_unit, LOAD_LATENCY 1 and 3 side by side
module tb_fwd_stall_hazard_unit;

  typedef struct {
    logic       idv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] used;
    logic [4:0] exrd;
    logic       exwe;
    logic       exld;
    logic [4:0] memrd;
    logic       memwe;
    logic       hold;
    logic       flush;
    logic       rstn;
    logic       st1;
    logic       st3;
    logic [3:0] fwd;
  } vec_t;

  typedef struct {
    logic [3:0] fwd;
    int         id;
  } sb_t;

  logic clk;
  logic rst_n;
  logic       id_valid;
  logic [9:0] rs_addr;
  logic [1:0] rs_used;
  logic [4:0] ex_rd;
  logic       ex_we;
  logic       ex_ld;
  logic [4:0] mem_rd;
  logic       mem_we;
  logic       hold;
  logic       flush;

  int   checks;
  int   failures;
  sb_t  sb[$];
  vec_t tbl[$];

  fwd_stall_hazard_unit_if #(.ADDR_W(5), .NUM_SRC(2)) hz1 ();
  fwd_stall_hazard_unit_if #(.ADDR_W(5), .NUM_SRC(2)) hz3 ();

  assign hz1.id_valid = id_valid;      assign hz3.id_valid = id_valid;
  assign hz1.rs_addr_id = rs_addr;     assign hz3.rs_addr_id = rs_addr;
  assign hz1.rs_used_id = rs_used;     assign hz3.rs_used_id = rs_used;
  assign hz1.ex_rd_addr = ex_rd;       assign hz3.ex_rd_addr = ex_rd;
  assign hz1.ex_reg_write = ex_we;     assign hz3.ex_reg_write = ex_we;
  assign hz1.ex_mem_read = ex_ld;      assign hz3.ex_mem_read = ex_ld;
  assign hz1.mem_rd_addr = mem_rd;     assign hz3.mem_rd_addr = mem_rd;
  assign hz1.mem_reg_write = mem_we;   assign hz3.mem_reg_write = mem_we;
  assign hz1.pipe_hold = hold;         assign hz3.pipe_hold = hold;
  assign hz1.flush = flush;            assign hz3.flush = flush;

`ifdef HAZARD_PERF_EN
  logic [15:0] sc1, fc1, sc3, fc3;
  int exp_sc1, exp_sc3, exp_fc;
`endif

  fwd_stall_hazard_unit #(.ADDR_W(5), .NUM_SRC(2), .LOAD_LATENCY(1), .CNT_W(16)) u_dut_l1 (
    .clk   (clk),
    .reset (rst_n),
    .hz    (hz1)
`ifdef HAZARD_PERF_EN
    ,
    .stall_count (sc1),
    .fwd_count   (fc1)
`endif
  );

  fwd_stall_hazard_unit #(.ADDR_W(5), .NUM_SRC(2), .LOAD_LATENCY(3), .CNT_W(16)) u_dut_l3 (
    .clk   (clk),
    .reset (rst_n),
    .hz    (hz3)
`ifdef HAZARD_PERF_EN
    ,
    .stall_count (sc3),
    .fwd_count   (fc3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [1:0] used, input logic [4:0] exrd, input logic exwe,
                              input logic exld, input logic [4:0] memrd, input logic memwe,
                              input logic hold_i, input logic flush_i, input logic rstn,
                              input logic st1, input logic st3, input logic [3:0] fwd);
    vec_t v;
    v.idv = idv;   v.rs1 = rs1;     v.rs2 = rs2;     v.used = used;
    v.exrd = exrd; v.exwe = exwe;   v.exld = exld;   v.memrd = memrd;
    v.memwe = memwe; v.hold = hold_i; v.flush = flush_i; v.rstn = rstn;
    v.st1 = st1;   v.st3 = st3;     v.fwd = fwd;
    return v;
  endfunction

  task automatic check(input string nm, input int id, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%b required=%b", nm, id, act, exp);
    end
  endtask

  // Drives at the falling edge, checks stalls mid-cycle, fwd_sel just after the rising edge.
  task automatic step(input vec_t v, input int id);
    sb_t e;
    rst_n = v.rstn;  id_valid = v.idv;   rs_addr = {v.rs2, v.rs1}; rs_used = v.used;
    ex_rd = v.exrd;  ex_we = v.exwe;     ex_ld = v.exld;
    mem_rd = v.memrd; mem_we = v.memwe;  hold = v.hold;  flush = v.flush;
    #1;
    check("stall_l1", id, {1'b0, hz1.stall_pc, hz1.stall_id, hz1.bubble_ex}, {1'b0, {3{v.st1}}});
    check("stall_l3", id, {1'b0, hz3.stall_pc, hz3.stall_id, hz3.bubble_ex}, {1'b0, {3{v.st3}}});
`ifdef HAZARD_PERF_EN
    if (!v.rstn) begin
      exp_sc1 = 0; exp_sc3 = 0; exp_fc = 0;
    end else begin
      if (v.st1 && !v.hold) exp_sc1++;
      if (v.st3 && !v.hold) exp_sc3++;
      if (v.fwd != 4'b0 && !v.hold && !v.flush) exp_fc++;
    end
`endif
    sb.push_back('{fwd: v.fwd, id: id});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("fwd_l1", e.id, hz1.fwd_sel, e.fwd);
    check("fwd_l3", e.id, hz3.fwd_sel, e.fwd);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
`ifdef HAZARD_PERF_EN
    exp_sc1 = 0; exp_sc3 = 0; exp_fc = 0;
`endif
    rst_n = 1'b0; id_valid = 1'b1; rs_addr = 10'd7; rs_used = 2'b01;
    ex_rd = 5'd7; ex_we = 1'b1; ex_ld = 1'b1; mem_rd = 5'd0; mem_we = 1'b0;
    hold = 1'b0; flush = 1'b0;

    //           idv rs1 rs2 used  exrd we ld memrd we hold fl rstn st1 st3 fwd
    tbl.push_back(mk(1, 5, 0, 2'b01, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0001));
    tbl.push_back(mk(1, 3, 5, 2'b11, 5, 1, 0, 5, 1, 0, 0, 1, 0, 0, 4'b0100));
    tbl.push_back(mk(1, 9, 0, 2'b01, 4, 1, 0, 9, 1, 0, 0, 1, 0, 0, 4'b0010));
    tbl.push_back(mk(1, 9, 9, 2'b11, 4, 1, 0, 9, 1, 0, 0, 1, 0, 0, 4'b1010));
    tbl.push_back(mk(1, 6, 8, 2'b11, 6, 1, 0, 8, 1, 0, 0, 1, 0, 0, 4'b1001));
    tbl.push_back(mk(1, 0, 0, 2'b11, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 5, 0, 2'b00, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 5, 0, 2'b01, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 7, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0, 1, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 9, 6, 2'b01, 6, 1, 0, 9, 1, 0, 0, 1, 0, 0, 4'b0010));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000));

    @(negedge clk);
    // reset held with a live load-use pattern on the inputs
    step(mk(1, 7, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000), 0);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1 + i);

    // load-use on rs1=x7: LL1 stalls 1 cycle, LL3 exactly 3, then WB select
    step(mk(1, 7, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0, 1, 1, 1, 4'b0000), 100);
    step(mk(1, 7, 0, 2'b01, 0, 0, 0, 7, 1, 0, 0, 1, 0, 1, 4'b0010), 101);
    step(mk(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4'b0000), 102);
    step(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000), 103);

    // reset pulse in the second stall cycle
    step(mk(1, 7, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0, 1, 1, 1, 4'b0000), 200);
    step(mk(1, 7, 0, 2'b01, 0, 0, 0, 7, 1, 0, 0, 1, 0, 1, 4'b0010), 201);
    step(mk(1, 7, 0, 2'b01, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 4'b0000), 202);
    step(mk(1, 7, 0, 2'b01, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 4'b0010), 203);
    step(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000), 204);

    // pipe_hold for 2 cycles mid-stall stretches LL3 to 5 cycles and freezes fwd_sel
    step(mk(1, 7, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0, 1, 1, 1, 4'b0000), 300);
    step(mk(1, 7, 0, 2'b01, 0, 0, 0, 7, 1, 0, 0, 1, 0, 1, 4'b0010), 301);
    step(mk(1, 7, 0, 2'b01, 0, 0, 0, 7, 1, 1, 0, 1, 0, 1, 4'b0010), 302);
    step(mk(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 4'b0010), 303);
    step(mk(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4'b0000), 304);
    step(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000), 305);

    // flush beats load-use, and beats pipe_hold on fwd_sel
    step(mk(1, 7, 9, 2'b11, 7, 1, 1, 9, 1, 0, 1, 1, 0, 0, 4'b0000), 400);
    step(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000), 401);
    step(mk(1, 5, 0, 2'b01, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0001), 402);
    step(mk(1, 5, 0, 2'b01, 5, 1, 0, 0, 0, 1, 1, 1, 0, 0, 4'b0000), 403);

    // back-to-back load-use: second hazard stalls in the cycle right after release
    step(mk(1, 7, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0, 1, 1, 1, 4'b0000), 500);
    step(mk(1, 7, 0, 2'b01, 0, 0, 0, 7, 1, 0, 0, 1, 0, 1, 4'b0010), 501);
    step(mk(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4'b0000), 502);
    step(mk(1, 0, 8, 2'b10, 8, 1, 1, 0, 0, 0, 0, 1, 1, 1, 4'b0000), 503);
    step(mk(1, 0, 8, 2'b10, 0, 0, 0, 8, 1, 0, 0, 1, 0, 1, 4'b1000), 504);
    step(mk(1, 0, 8, 2'b10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4'b0000), 505);
    step(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000), 506);

`ifdef HAZARD_PERF_EN
    check("stall_count_l1", 600, sc1[3:0], 4'(exp_sc1));
    check("stall_count_l3", 601, sc3[3:0], 4'(exp_sc3));
    check("fwd_count_l1",   602, fc1[3:0], 4'(exp_fc));
    check("fwd_count_l3",   603, fc3[3:0], 4'(exp_fc));
`endif

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    checks++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_stall_hazard_unit.md
# fwd_stall_hazard_unit

Parametrised data-hazard unit for the 5-stage RISC-V pipeline. It compares the source-register addresses of the instruction in ID against the destinations in EX (ALU) and MEM. It registers per-source forwarding selects for use in EX on the next cycle. It also detects load-use hazards and runs a small state machine that stalls IF/ID and inserts EX bubbles for a configurable load latency.

## Interface
Parameters:
- ADDR_W, 5, register address width
- NUM_SRC, 2, source operands per instruction (rs1, rs2[, rs3])
- LOAD_LATENCY, 1, stall cycles required per load-use hazard (1..15)
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- id_valid  in  1  ID holds a real instruction
- rs_addr_id  in  NUM_SRC*ADDR_W  source addresses, src i at [i*ADDR_W +: ADDR_W]
- rs_used_id  in  NUM_SRC  source i is actually read
- ex_rd_addr  in  ADDR_W  destination of the instruction in EX
- ex_reg_write  in  1  EX instruction writes the register file
- ex_mem_read  in  1  EX instruction is a load
- mem_rd_addr  in  ADDR_W  destination of the instruction in MEM
- mem_reg_write  in  1  MEM instruction writes the register file
- pipe_hold  in  1  global freeze from the memory system
- flush  in  1  branch/jump flush of IF/ID
- fwd_sel  out  NUM_SRC*2  per-source select for EX: 00 none, 01 from MEM, 10 from WB
- stall_pc  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- bubble_ex  out  1  load NOP into ID/EX
- stall_count, fwd_count  out  CNT_W each  present only with HAZARD_PERF_EN

## Operation
- Match for src i against stage S: rs_used_id[i] & S_reg_write & (S_rd == rs_i) & (S_rd != 0). x0 is never forwarded.
- Forward select per source: an EX match gives 01 (the producer will be in MEM next cycle). Otherwise a MEM match gives 10 (the producer will be in WB). Otherwise 00. EX takes priority over MEM.
- A load-use hit is any id_valid & ex_mem_read & EX match on any source.
- The FSM has two states:
  - IDLE: stall outputs follow the combinational load-use hit. On a hit with LOAD_LATENCY>1, go to STALL with cnt = LOAD_LATENCY-1.
  - STALL: stall outputs are asserted and cnt decrements each cycle. When cnt reaches 1 and decrements, return to IDLE.
- The load-use hit term ignores the EX bubble that the stall creates.
- stall_pc = stall_id = bubble_ex = (load_use_hit in IDLE) | (state==STALL), gated off by flush.
- A load-use hit never forwards from EX. fwd_sel for the hazarding source is registered as 00 during a stall cycle. The correct WB select is produced on the cycle the stall releases.

## Timing
- fwd_sel is registered with 1-cycle latency: it is computed from the ID/EX/MEM inputs before edge N and valid after edge N.
- The stall outputs are combinational in IDLE and registered in STALL. A hazard stalls exactly LOAD_LATENCY consecutive cycles, starting in the detection cycle.
- pipe_hold=1: fwd_sel, FSM state and cnt are frozen. Stall outputs keep their current value.
- flush=1 at an edge: fwd_sel becomes 0, FSM goes to IDLE, and the stall outputs are low in that cycle. flush overrides both pipe_hold and load-use.
- Reset, asynchronous, including mid-stall: fwd_sel=0, FSM=IDLE, cnt=0, counters=0, and all stall outputs are 0 while reset is low.
- Back-to-back load-use hazards re-enter STALL directly from the IDLE release cycle with no gap.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_count increments every cycle stall_id=1 and pipe_hold=0.
  - fwd_count increments every edge on which any fwd_sel becomes nonzero.
  - Both counters saturate at all-ones and are cleared by reset.
- HAZARD_PERF_EN undefined: the counter ports and logic are absent, and behaviour is otherwise identical.

## Structure
- Shared package hazard_pkg holds:
  - FWD_NONE/FWD_MEM/FWD_WB (2-bit constants)
  - the state typedef: IDLE, STALL
  - the default ADDR_W
- Sub-module hazard_addr_cmp (one per source per stage) takes rd, rs, reg_write and used, and outputs a match. It carries the x0 exclusion.

## Test plan
- add x5 in EX, ID reads rs1=x5 -> fwd_sel[1:0]=01 after next edge, no stall.
- x5 in both EX and MEM, ID rs2=x5 -> fwd_sel[3:2]=01 (EX priority).
- lw x7 in EX, ID uses rs1=x7, LOAD_LATENCY=1 -> stall/bubble high 1 cycle, then fwd_sel[1:0]=10.
- LOAD_LATENCY=3, load-use -> stall_id high exactly 3 cycles. A reset pulse in cycle 2 drops all stall outputs immediately and FSM=IDLE.
- rd=x0 with reg_write=1, rs1=x0 -> fwd_sel=00, no stall. pipe_hold=1 for 2 cycles mid-stall extends the stall by 2.
- flush asserted during a load-use hit -> no stall that cycle, fwd_sel=00 next edge. With HAZARD_PERF_EN, stall_count is unchanged.
